// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums N_TERMS multiplier products (one per rising edge of
//               mult_done) and presents each window sum on a valid/ready port.
//               Optional macro ACCUM_SAT_EN: saturate instead of wrap on carry.
// Revision    : 1.0
// ============================================================================
module product_accumulator #(
    parameter int PROD_W  = 17,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_done,
    input  logic [PROD_W-1:0] mult_product,
    input  logic              acc_clear,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              drop_err,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_n_terms = CNT_W'(N_TERMS);

    state_t             r_state;
    logic               r_done_q;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_pend;
    logic               r_pend_valid;
    logic [ACC_W-1:0]   r_sum_out;
    logic               r_sum_valid;
    logic               r_overflow;
    logic               r_drop_err;

    state_t             w_state_nx;
    logic [ACC_W-1:0]   w_acc_nx;
    logic [CNT_W-1:0]   w_count_nx;
    logic [ACC_W-1:0]   w_pend_nx;
    logic               w_pend_valid_nx;
    logic [ACC_W-1:0]   w_sum_out_nx;
    logic               w_sum_valid_nx;
    logic               w_overflow_nx;
    logic               w_drop_err_nx;

    logic               w_cap;
    logic [ACC_W-1:0]   w_prod_ext;
    logic               w_window;
    logic [ACC_W-1:0]   w_base_acc;
    logic [CNT_W-1:0]   w_base_cnt;
    logic               w_base_ovf;
    logic [ACC_W:0]     w_add_full;

    assign w_cap      = mult_done & ~r_done_q;
    assign w_prod_ext = ACC_W'(mult_product);

    // w_window marks a cycle in which the accumulator takes captures; on the
    // handshake it starts from the pending product (or zero) instead of r_acc.
    always_comb begin
        w_state_nx      = r_state;
        w_acc_nx        = r_acc;
        w_count_nx      = r_count;
        w_pend_nx       = r_pend;
        w_pend_valid_nx = r_pend_valid;
        w_sum_out_nx    = r_sum_out;
        w_sum_valid_nx  = r_sum_valid;
        w_overflow_nx   = r_overflow;
        w_drop_err_nx   = r_drop_err;
        w_window        = 1'b0;
        w_base_acc      = r_acc;
        w_base_cnt      = r_count;
        w_base_ovf      = r_overflow;
        w_add_full      = '0;

        if (acc_clear) begin
            w_state_nx      = ST_ACCUM;
            w_acc_nx        = '0;
            w_count_nx      = '0;
            w_pend_valid_nx = 1'b0;
            w_sum_valid_nx  = 1'b0;
            w_overflow_nx   = 1'b0;
            w_drop_err_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: w_window = 1'b1;
                ST_HOLD: begin
                    if (r_sum_valid && sum_ready) begin
                        w_window        = 1'b1;
                        w_sum_valid_nx  = 1'b0;
                        w_base_ovf      = 1'b0;
                        w_pend_valid_nx = 1'b0;
                        if (r_pend_valid) begin
                            w_base_acc = r_pend;
                            w_base_cnt = CNT_W'(1);
                        end else begin
                            w_base_acc = '0;
                            w_base_cnt = '0;
                        end
                    end else if (w_cap) begin
                        if (r_pend_valid) begin
                            w_drop_err_nx = 1'b1;
                        end else begin
                            w_pend_nx       = w_prod_ext;
                            w_pend_valid_nx = 1'b1;
                        end
                    end
                end
                default: w_state_nx = ST_ACCUM;
            endcase

            if (w_window) begin
                w_state_nx    = ST_ACCUM;
                w_acc_nx      = w_base_acc;
                w_count_nx    = w_base_cnt;
                w_overflow_nx = w_base_ovf;
                if (w_cap) begin
                    w_add_full    = {1'b0, w_base_acc} + {1'b0, w_prod_ext};
                    w_count_nx    = w_base_cnt + CNT_W'(1);
                    w_overflow_nx = w_base_ovf | w_add_full[ACC_W];
`ifdef ACCUM_SAT_EN
                    w_acc_nx = w_add_full[ACC_W] ? {ACC_W{1'b1}} : w_add_full[ACC_W-1:0];
`else
                    w_acc_nx = w_add_full[ACC_W-1:0];
`endif
                end
                if (w_count_nx == c_n_terms) begin
                    w_sum_out_nx   = w_acc_nx;
                    w_sum_valid_nx = 1'b1;
                    w_state_nx     = ST_HOLD;
                end
            end
        end
    end

    // done_q resets high so a done already asserted at reset release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ACCUM;
            r_done_q     <= 1'b1;
            r_acc        <= '0;
            r_count      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_sum_out    <= '0;
            r_sum_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_done_q     <= mult_done;
            r_acc        <= w_acc_nx;
            r_count      <= w_count_nx;
            r_pend       <= w_pend_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_sum_out    <= w_sum_out_nx;
            r_sum_valid  <= w_sum_valid_nx;
            r_overflow   <= w_overflow_nx;
            r_drop_err   <= w_drop_err_nx;
        end
    end

    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_err  = r_drop_err;
    assign busy      = (r_count != '0) | r_sum_valid;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Scoreboard bench for product_accumulator (ACC_W=18, N_TERMS=4).
// Revision    : 1.0
// ============================================================================
module tb_product_accumulator;

    localparam int PROD_W  = 17;
    localparam int ACC_W   = 18;
    localparam int N_TERMS = 4;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              mult_done;
    logic [PROD_W-1:0] mult_product;
    logic              acc_clear;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              drop_err;
    logic              busy;

    int  errors = 0;
    int  checks = 0;
    sb_t sb_q[$];

    product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .N_TERMS(N_TERMS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mult_done   (mult_done),
        .mult_product(mult_product),
        .acc_clear   (acc_clear),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .count       (count),
        .overflow    (overflow),
        .drop_err    (drop_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Expected window result from the plain sum of its products.
    function automatic sb_t expect_window(input longint total);
        sb_t    e;
        longint lim;
        lim   = longint'(1) << ACC_W;
        e.ovf = (total >= lim);
`ifdef ACCUM_SAT_EN
        e.sum = e.ovf ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
        e.sum = total[ACC_W-1:0];
`endif
        return e;
    endfunction

    // Handshake monitor: inputs settle at negedge, so sample 1 ns later.
    always @(negedge clk) begin
        #1;
        if (sum_valid && sum_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sum=%h ovf=%b, none expected", sum_out, overflow);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (sum_out !== e.sum || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL sb_sum: got sum=%h ovf=%b, expected sum=%h ovf=%b",
                             sum_out, overflow, e.sum, e.ovf);
                end
            end
        end
    end

    task automatic pulse(input logic [PROD_W-1:0] p);
        @(negedge clk);
        mult_product = p;
        mult_done    = 1'b1;
        @(negedge clk);
        mult_done    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; mult_done = 1'b0; mult_product = '0;
        acc_clear = 1'b0; sum_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sum_out, sum_valid, count, overflow, drop_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: got sum=%h v=%b cnt=%0d ovf=%b drop=%b busy=%b, expected all 0",
                     sum_out, sum_valid, count, overflow, drop_err, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        sb_q.push_back(expect_window(100));
        pulse(10); pulse(20);
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL basic_count2: got %0d expected 2", count); end
        pulse(30); pulse(40);
        checks++;
        if (sum_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", sum_valid); end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0 || count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: got v=%b cnt=%0d busy=%b expected 0/0/0", sum_valid, count, busy);
        end
    endtask

    task automatic test_held_done;
        sb_q.push_back(expect_window(5 + 6 + 7 + 8));
        @(negedge clk);
        mult_product = 5; mult_done = 1'b1;
        repeat (50) @(negedge clk);
        mult_done = 1'b0;
        @(negedge clk);
        mult_product = 6; mult_done = 1'b1;
        repeat (3) @(negedge clk);
        mult_done = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL held_count: got %0d expected 2", count); end
        pulse(7); pulse(8);
        @(negedge clk);
    endtask

    task automatic test_pend_drop;
        sum_ready = 1'b0;
        sb_q.push_back(expect_window(10));
        pulse(1); pulse(2); pulse(3); pulse(4);
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== 18'd10 || count !== 4'd4) begin
            errors++;
            $display("FAIL hold_state: got v=%b sum=%0d cnt=%0d expected 1/10/4", sum_valid, sum_out, count);
        end
        pulse(7);
        checks++;
        if (drop_err !== 1'b0) begin errors++; $display("FAIL pend_nodrop: got %b expected 0", drop_err); end
        pulse(9);
        checks++;
        if (drop_err !== 1'b1 || sum_out !== 18'd10 || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop: got drop=%b sum=%0d v=%b expected 1/10/1", drop_err, sum_out, sum_valid);
        end
        sb_q.push_back(expect_window(7 + 2 + 3 + 4));
        @(negedge clk);
        sum_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 4'd1 || sum_valid !== 1'b0 || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL pend_load: got cnt=%0d v=%b drop=%b expected 1/0/1", count, sum_valid, drop_err);
        end
        pulse(2); pulse(3); pulse(4);
        @(negedge clk);
    endtask

    task automatic test_clear;
        pulse(2); pulse(3);
        @(negedge clk);
        acc_clear = 1'b1; mult_product = 50; mult_done = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0; mult_done = 1'b0;
        checks++;
        if (count !== '0 || sum_valid !== 1'b0 || drop_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear: got cnt=%0d v=%b drop=%b busy=%b expected 0/0/0/0",
                     count, sum_valid, drop_err, busy);
        end
        sb_q.push_back(expect_window(3 + 4 + 5 + 6));
        pulse(3);
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL clear_next: got %0d expected 1", count); end
        pulse(4); pulse(5); pulse(6);
        @(negedge clk);
    endtask

    task automatic test_overflow;
        sb_q.push_back(expect_window(4 * 64'h1FFFF));
        pulse(17'h1FFFF); pulse(17'h1FFFF);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        pulse(17'h1FFFF);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        pulse(17'h1FFFF);
        sb_q.push_back(expect_window(10));
        pulse(1); pulse(2); pulse(3); pulse(4);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        pulse(1); pulse(2); pulse(3);
        checks++;
        if (count !== 4'd3) begin errors++; $display("FAIL mid_count: got %0d expected 3", count); end
        @(negedge clk);
        reset = 1'b1; mult_product = 9; mult_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({sum_out, sum_valid, count, overflow, drop_err, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got sum=%h v=%b cnt=%0d ovf=%b drop=%b busy=%b expected all 0",
                     sum_out, sum_valid, count, overflow, drop_err, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (count !== '0) begin errors++; $display("FAIL mid_nocap: got %0d expected 0", count); end
        mult_done = 1'b0;
        sb_q.push_back(expect_window(10));
        pulse(1); pulse(2); pulse(3); pulse(4);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_done();
        test_pend_drop();
        test_clear();
        test_overflow();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending windows expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
